// File: rtl/pipe_stage_chain.sv
// ---------------------------------------------------------------------------
// pipe_stage_chain
//
// Elastic chain of DEPTH pipeline registers, each WIDTH bits wide and each
// carrying a valid bit. It replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB
// registers. Stage 0 is the youngest stage and stage DEPTH-1 is the oldest.
// The chain supports per-stage stall (hazard hold), per-stage flush
// (branch/interrupt kill), bubble collapsing, and a valid/ready handshake at
// each end.
//
// Ports
//   clk           clock; all state changes on the rising edge
//   rst           synchronous, active-high reset; clears every valid bit,
//                 every payload and the perf state
//   in_valid      upstream offers in_data
//   in_data       payload entering stage 0
//   in_ready      stage 0 accepts this cycle
//   stall_req     bit k: stage k holds its contents and accepts nothing
//   flush_req     bit k: kill stages 0..k at the next edge
//   out_valid     valid bit of stage DEPTH-1
//   out_data      payload of stage DEPTH-1
//   out_ready     downstream consumes out_data
//   stage_valid   valid bit of every stage
//   stage_data    all payloads; stage k at [k*WIDTH +: WIDTH]
//   occupancy     registered count of valid stages (perf build only)
//   stall_cycles  saturating count of cycles in which a live entry could not
//                 advance (perf build only)
//
// Build option
//   PIPE_STAGE_PERF_EN : when defined, builds the occupancy and stall_cycles
//                        counters. When undefined, both outputs are tied to 0.
// ---------------------------------------------------------------------------
module pipe_stage_chain #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    input  logic [DEPTH-1:0]           stall_req,
    input  logic [DEPTH-1:0]           flush_req,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [DEPTH-1:0]           stage_valid,
    output logic [DEPTH*WIDTH-1:0]     stage_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           stall_cycles
);

    localparam int OCC_W = $clog2(DEPTH+1);

    // Registered stage state
    logic [DEPTH-1:0] v_q;
    logic [WIDTH-1:0] d_q   [DEPTH];

    // Next-state values
    logic [DEPTH-1:0] v_nxt;
    logic [WIDTH-1:0] d_nxt [DEPTH];

    // Per-stage handshake terms
    logic [DEPTH-1:0] adv;   // stage k hands its entry downstream this cycle
    logic [DEPTH-1:0] acc;   // stage k can take a new entry this cycle
    logic [DEPTH-1:0] kill;  // stage k is cleared at the next edge

    // Walk from the oldest stage to the youngest. Scalar temporaries carry
    // the downstream accept and the cumulative flush, so the block never
    // reads back its own vector outputs.
    always_comb begin : handshake
        logic down_acc;
        logic kill_acc;
        logic adv_k;
        down_acc = out_ready;
        kill_acc = 1'b0;
        adv_k    = 1'b0;
        adv      = '0;
        acc      = '0;
        kill     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            kill_acc             = kill_acc | flush_req[DEPTH-1-i];
            kill[DEPTH-1-i]      = kill_acc;
            adv_k                = v_q[DEPTH-1-i] & ~stall_req[DEPTH-1-i] & down_acc;
            adv[DEPTH-1-i]       = adv_k;
            down_acc             = ~stall_req[DEPTH-1-i] & (~v_q[DEPTH-1-i] | adv_k);
            acc[DEPTH-1-i]       = down_acc;
        end
    end

    assign in_ready = acc[0] & ~kill[0];

    always_comb begin : next_state
        v_nxt = v_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            d_nxt[i] = d_q[i];
        end

        // Stage 0 loads from the upstream port. Without an offer, the stage
        // becomes empty but keeps its old payload.
        if (kill[0]) begin
            v_nxt[0] = 1'b0;
            d_nxt[0] = '0;
        end else if (acc[0]) begin
            v_nxt[0] = in_valid;
            if (in_valid) begin
                d_nxt[0] = in_data;
            end
        end

        // Later stages load from their upstream neighbour. A neighbour that
        // is empty or killed passes on a zeroed bubble, never its payload.
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (kill[i]) begin
                v_nxt[i] = 1'b0;
                d_nxt[i] = '0;
            end else if (acc[i]) begin
                if (adv[i-1] & ~kill[i-1]) begin
                    v_nxt[i] = 1'b1;
                    d_nxt[i] = d_q[i-1];
                end else begin
                    v_nxt[i] = 1'b0;
                    d_nxt[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q <= v_nxt;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                d_q[i] <= d_nxt[i];
            end
        end
    end

    assign out_valid   = v_q[DEPTH-1];
    assign out_data    = d_q[DEPTH-1];
    assign stage_valid = v_q;

    always_comb begin : pack_data
        stage_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_data[i*WIDTH +: WIDTH] = d_q[i];
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_nxt;
    logic [CNT_W-1:0] stall_q;
    logic             stalled;

    // A live entry that cannot move on and is not being flushed counts as
    // one stalled cycle, however many stages are stuck.
    always_comb begin : perf_terms
        occ_nxt = '0;
        stalled = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occ_nxt = occ_nxt + OCC_W'(v_nxt[i]);
            stalled = stalled | (v_q[i] & ~adv[i] & ~kill[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q   <= '0;
            stall_q <= '0;
        end else begin
            occ_q <= occ_nxt;
            if (stalled && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign occupancy    = occ_q;
    assign stall_cycles = stall_q;
`else
    // The oldest stage's advance term only feeds the perf counter.
    logic perf_unused;
    assign perf_unused  = adv[DEPTH-1];
    assign occupancy    = '0;
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_chain
//
// Directed testbench for pipe_stage_chain with WIDTH=16 and DEPTH=4. Each
// scenario drives inputs just after a rising edge and samples outputs 1 ns
// after the following edge. Expected values are worked out by hand for every
// vector.
// ---------------------------------------------------------------------------
module tb_pipe_stage_chain;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = 32;
    localparam int OCC_W = $clog2(DEPTH+1);

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [63:0] EXP_OCC_FULL = 64'd4;
    localparam logic [63:0] EXP_STALL_BP = 64'd5;
`else
    localparam logic [63:0] EXP_OCC_FULL = 64'd0;
    localparam logic [63:0] EXP_STALL_BP = 64'd0;
`endif

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic                   in_ready;
    logic [DEPTH-1:0]       stall_req;
    logic [DEPTH-1:0]       flush_req;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic                   out_ready;
    logic [DEPTH-1:0]       stage_valid;
    logic [DEPTH*WIDTH-1:0] stage_data;
    logic [OCC_W-1:0]       occupancy;
    logic [CNT_W-1:0]       stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_chain #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .stall_req   (stall_req),
        .flush_req   (flush_req),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .occupancy   (occupancy),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; return 1 ns after it so registered outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [WIDTH-1:0] data);
        in_valid = valid;
        in_data  = data;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        stall_req = '0;
        flush_req = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_out_valid",   64'(out_valid),    64'd0);
        check("rst_out_data",    64'(out_data),     64'd0);
        check("rst_stage_valid", 64'(stage_valid),  64'd0);
        check("rst_stage_data",  64'(stage_data),   64'd0);
        check("rst_occupancy",   64'(occupancy),    64'd0);
        check("rst_stall",       64'(stall_cycles), 64'd0);
        check("empty_in_ready",  64'(in_ready),     64'd1);
        flush_req = 4'b1000;
        #1;
        check("empty_flush_in_ready", 64'(in_ready), 64'd0);
        flush_req = 4'b0000;
        stall_req = 4'b0001;
        #1;
        check("empty_stall0_in_ready", 64'(in_ready), 64'd0);
        stall_req = 4'b0000;

        // Streaming: words 1..8; word e appears after edge e+3
        out_ready = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            drive(e <= 8, WIDTH'(e));
            #1;
            if (e <= 8) check("stream_in_ready", 64'(in_ready), 64'd1);
            tick();
            if (e >= 4) begin
                check("stream_out_valid", 64'(out_valid), 64'd1);
                check("stream_out_data",  64'(out_data),  64'(e - 3));
            end else begin
                check("stream_out_valid_lat", 64'(out_valid), 64'd0);
            end
        end
        drive(1'b0, '0);
        tick();
        check("stream_drained", 64'(stage_valid), 64'd0);

        // Back-pressure: fill with A0..A3, then hold out_ready low for 5 edges
        out_ready = 1'b0;
        for (int e = 0; e < 4; e++) begin
            drive(1'b1, WIDTH'(16'h00A0 + e));
            tick();
        end
        check("bp_fill_valid", 64'(stage_valid), 64'hF);
        check("bp_fill_occ",   64'(occupancy),   EXP_OCC_FULL);
        drive(1'b1, 16'h00EE);
        for (int e = 0; e < 5; e++) begin
            #1;
            check("bp_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        check("bp_hold_data",  64'(stage_data),   64'h00A0_00A1_00A2_00A3);
        check("bp_hold_valid", 64'(stage_valid),  64'hF);
        check("bp_hold_occ",   64'(occupancy),    EXP_OCC_FULL);
        check("bp_stall_cnt",  64'(stall_cycles), EXP_STALL_BP);
        drive(1'b0, '0);
        out_ready = 1'b1;
        #1;
        check("bp_rel_valid0", 64'(out_valid), 64'd1);
        check("bp_rel_data0",  64'(out_data),  64'h00A0);
        for (int e = 1; e <= 3; e++) begin
            tick();
            check("bp_rel_valid", 64'(out_valid), 64'd1);
            check("bp_rel_data",  64'(out_data),  64'(16'h00A0 + e));
        end
        tick();
        check("bp_rel_empty",     64'(out_valid),    64'd0);
        check("bp_rel_occ",       64'(occupancy),    64'd0);
        check("bp_rel_stall_cnt", 64'(stall_cycles), EXP_STALL_BP);

        // Bubble collapse: build {3:B3, 2:empty, 1:B1, 0:B0}
        out_ready = 1'b0;
        drive(1'b1, 16'h00B3); tick();
        drive(1'b0, 16'h0000); tick();
        drive(1'b1, 16'h00B1); tick();
        drive(1'b1, 16'h00B0); tick();
        check("bub_setup_valid", 64'(stage_valid), 64'b1011);
        check("bub_setup_data",  64'(stage_data),  64'h00B3_0000_00B1_00B0);
        stall_req = 4'b1000;
        drive(1'b1, 16'h00B4);
        #1;
        check("bub_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("bub_valid", 64'(stage_valid), 64'hF);
        check("bub_data",  64'(stage_data),  64'h00B3_00B1_00B0_00B4);
        stall_req = 4'b0000;
        drive(1'b0, '0);

        // Flush everything
        flush_req = 4'b1111;
        tick();
        flush_req = 4'b0000;
        check("flushall_valid", 64'(stage_valid), 64'd0);
        check("flushall_data",  64'(stage_data),  64'd0);

        // Flush at stage 1 while stage 3 transfers out
        drive(1'b1, 16'h00C3); tick();
        drive(1'b1, 16'h00C2); tick();
        drive(1'b1, 16'h00C1); tick();
        drive(1'b1, 16'h00C0); tick();
        check("fl_setup_data", 64'(stage_data), 64'h00C3_00C2_00C1_00C0);
        flush_req = 4'b0010;
        out_ready = 1'b1;
        drive(1'b1, 16'h00DD);
        #1;
        check("fl_in_ready",  64'(in_ready),  64'd0);
        check("fl_out_valid", 64'(out_valid), 64'd1);
        check("fl_out_data",  64'(out_data),  64'h00C3);
        tick();
        flush_req = 4'b0000;
        drive(1'b0, '0);
        check("fl_valid", 64'(stage_valid), 64'b1000);
        check("fl_data",  64'(stage_data),  64'h00C2_0000_0000_0000);

        // Flush of the oldest stage still lets its transfer complete
        flush_req = 4'b1000;
        #1;
        check("fl3_out_valid", 64'(out_valid), 64'd1);
        check("fl3_out_data",  64'(out_data),  64'h00C2);
        tick();
        flush_req = 4'b0000;
        check("fl3_valid", 64'(stage_valid), 64'd0);

        // Reset with a full chain and an offered word
        out_ready = 1'b0;
        drive(1'b1, 16'h0011); tick();
        drive(1'b1, 16'h0022); tick();
        drive(1'b1, 16'h0033); tick();
        drive(1'b1, 16'h0044); tick();
        check("mr_full", 64'(stage_valid), 64'hF);
        rst = 1'b1;
        drive(1'b1, 16'h0055);
        tick();
        rst = 1'b0;
        check("mr_out_valid",   64'(out_valid),    64'd0);
        check("mr_out_data",    64'(out_data),     64'd0);
        check("mr_stage_valid", 64'(stage_valid),  64'd0);
        check("mr_stage_data",  64'(stage_data),   64'd0);
        check("mr_occupancy",   64'(occupancy),    64'd0);
        check("mr_stall",       64'(stall_cycles), 64'd0);
        out_ready = 1'b1;
        drive(1'b1, 16'h0066);
        for (int e = 1; e <= 4; e++) begin
            tick();
            drive(1'b0, '0);
            if (e < 4) begin
                check("mr_lat_valid", 64'(out_valid), 64'd0);
            end else begin
                check("mr_lat_out_valid", 64'(out_valid), 64'd1);
                check("mr_lat_out_data",  64'(out_data),  64'h0066);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised, elastic inter-stage pipeline register chain for the RISC processor.
- Generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers: DEPTH stages of WIDTH-bit payload, each with a valid bit.
- Supports per-stage stall (hazard hold), per-stage flush (branch/interrupt kill), bubble collapsing and valid/ready handshakes at both ends.
- Sits between the fetch and write-back logic; the hazard and branch units drive stall_req and flush_req.

Parameters:
- WIDTH, 64, payload bits per stage.
- DEPTH, 4, number of stages (≥2); stage 0 is youngest, stage DEPTH-1 is oldest.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  upstream offers in_data.
- in_data  input  WIDTH  payload entering stage 0.
- in_ready  output  1  stage 0 accepts this cycle.
- stall_req  input  DEPTH  bit k: stage k holds its contents and accepts nothing.
- flush_req  input  DEPTH  bit k: kill stages 0..k at the next edge.
- out_valid  output  1  valid bit of stage DEPTH-1.
- out_data  output  WIDTH  payload of stage DEPTH-1.
- out_ready  input  1  downstream consumes out_data.
- stage_valid  output  DEPTH  valid bit of every stage.
- stage_data  output  DEPTH*WIDTH  all stage payloads; stage k occupies [k*WIDTH +: WIDTH].
- occupancy  output  $clog2(DEPTH+1)  number of valid stages (optional feature).
- stall_cycles  output  CNT_W  perf counter (optional feature).

Behaviour:
- Reset: on a rising edge with rst=1, all valid bits and all payloads are cleared to 0. Consequently out_valid=0, out_data=0, stage_valid=0, stage_data=0, occupancy=0, stall_cycles=0. rst takes priority over every other input. Reset asserted mid-transfer discards all in-flight data, with no partial output.
- Per-stage logic is combinational, evaluated from oldest stage to youngest:
  - adv[D-1] = v[D-1] & ~stall_req[D-1] & out_ready
  - adv[k] = v[k] & ~stall_req[k] & acc[k+1]
  - acc[k] = ~stall_req[k] & (~v[k] | adv[k])
- Bubble collapsing: an empty stage accepts a new entry even when the stages downstream of it are held.
- kill[k] = OR of flush_req[DEPTH-1:k]. A flush at stage j kills stages 0..j.
- in_ready = acc[0] & ~kill[0]. Data is never silently dropped.
- Next state for stage k, in priority order:
  - if kill[k]: v=0, data=0.
  - else if acc[k]:
    - k=0: load in_valid/in_data. If in_valid=0, v=0 and data is held.
    - k>0: load from stage k-1 when adv[k-1] & ~kill[k-1]; otherwise v=0 (bubble).
  - else: hold.
- An output transfer (out_valid & out_ready) completes in the same cycle even if flush_req[DEPTH-1]=1. The flush clears the register only at the edge.
- A killed upstream stage that advances delivers a bubble, never its payload.
- Latency: data accepted at edge n appears on out_data after edge n+DEPTH-1 when no stalls occur. Throughput is 1 per cycle.
- Full chain with out_ready=0: in_ready=0 and every stage holds.
- Empty chain: out_valid=0. in_ready=1 unless stall_req[0] or any flush bit is set.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - occupancy is a registered popcount of the next-state valid bits, updated every edge.
  - stall_cycles increments on each cycle where some valid stage has ~adv and is not killed. It saturates at all-ones and is cleared by rst.
- Undefined: occupancy and stall_cycles are driven to constant 0 and no counter logic exists.

Test Plan:
- Streaming (DEPTH=4, WIDTH=16, out_ready=1): feed 0x0001..0x0008 on consecutive cycles. Required: out_data shows 0x0001 after the 4th edge, then one word per cycle; in_ready stays 1.
- Back-pressure: fill the chain with 0xA0..0xA3, hold out_ready=0 for 5 cycles. Required: in_ready=0, occupancy=4, data unchanged, stall_cycles=5 (feature on). Release out_ready: 0xA0, 0xA1, 0xA2, 0xA3 emerge in order.
- Bubble collapse: stages {3:0xB3, 2:empty, 1:0xB1, 0:0xB0}, stall_req=4'b1000. Required after one edge: stage 2=0xB1, stage 1=0xB0, stage 0=in_data, stage 3=0xB3 held.
- Flush: stages full with 0xC0..0xC3, flush_req=4'b0010 for one cycle with out_ready=1. Required: 0xC3 is output that cycle; afterwards stage 3=0xC2, stages 0..2 are invalid with data 0, and in_ready was 0 during the flush.
- Reset mid-operation: with a full chain, assert rst for 1 cycle alongside in_valid=1 and flush_req=0. Required: all outputs 0 after the edge; the next accepted word reaches out_data exactly 4 edges later.
- Macro off: rerun the back-pressure test. Required: occupancy=0 and stall_cycles=0 throughout, with data behaviour identical.
